tx_estado_uart: RTL and testbench

- Serial status transmitter for the hyperthermia-prevention system.
- Takes a snapshot of the registered system status (5-bit temperature, presence, car ignition, 2-bit alarm/vent) and sends it as a fixed 4-byte UART frame (8N1, LSB first) on one output pin, for logging by an external monitor.
- Sits beside the input/output registers at top level.
- It is the outbound counterpart of the parallel sensor-input path.

---
 rtl/tx_estado_uart_pkg.sv | 30 +++
 rtl/tx_estado_uart_byte.sv | 48 ++++
 rtl/tx_estado_uart.sv | 97 +++++++++
 tb/tb_tx_estado_uart.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_estado_uart_pkg.sv
// Shared definitions for the status UART transmitter: state encoding,
// frame geometry and the byte selector for the 4-byte status frame.
package tx_estado_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int unsigned NUM_BYTES   = 4;
    localparam logic [7:0]  HDR_DEFAULT = 8'hA5;
    localparam int unsigned BIT_W       = 3;
    localparam int unsigned BYTE_W      = 2;

    // B0 = header, B1/B2 = snapshot, B3 = XOR check of B1 and B2
    function automatic logic [7:0] frame_byte(input logic [BYTE_W-1:0] idx,
                                              input logic [7:0] hdr,
                                              input logic [7:0] b1,
                                              input logic [7:0] b2);
        case (idx)
            2'd0:    return hdr;
            2'd1:    return b1;
            2'd2:    return b2;
            default: return b1 ^ b2;
        endcase
    endfunction

endpackage

// File: rtl/tx_estado_uart_byte.sv
// One 8N1 byte serializer: baud counter plus 10-bit shift register.
// A load is taken when ready, including on the last stop-bit cycle, so bytes chain without gaps.
module tx_byte_uart #(
    parameter int unsigned DIV = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       tick,
    output logic       ready
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic [3:0]    pos;
    logic          active;
    logic [9:0]    sh;

    assign tick  = active && (cnt == CW'(DIV - 1));
    assign ready = !active || (tick && (pos == 4'd9));
    assign tx    = sh[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            pos    <= '0;
            active <= 1'b0;
            sh     <= '1;
        end else if (load && ready) begin
            sh     <= {1'b1, data, 1'b0};
            cnt    <= '0;
            pos    <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (tick) begin
                cnt <= '0;
                sh  <= {1'b1, sh[9:1]};
                if (pos == 4'd9) active <= 1'b0;
                else             pos    <= pos + 4'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/tx_estado_uart.sv
// Status frame transmitter: snapshots the system status and sends
// header, temperature, flags and XOR check as four back-to-back 8N1 bytes.
module tx_estado_uart
    import tx_estado_uart_pkg::*;
#(
    parameter int unsigned DIV = 5208,
    parameter logic [7:0]  HDR = HDR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] temp,
    input  logic       pres,
    input  logic       carro,
    input  logic [1:0] alarm,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    state_t            state;
    logic [BIT_W-1:0]  bit_idx;
    logic [BYTE_W-1:0] byte_idx;
    logic [7:0]        b1;
    logic [7:0]        b2;
    logic [BYTE_W-1:0] sel;
    logic              last_byte;
    logic              load;
    logic              tick;
    logic              ready;

    assign last_byte = (byte_idx == BYTE_W'(NUM_BYTES - 1));

    // The serializer loads on the same edge the FSM advances, so the byte
    // presented is the one the FSM is about to enter.
    always_comb begin
        sel = '0;
        if (state != IDLE) sel = byte_idx + BYTE_W'(1);
    end

    assign load = ((state == IDLE) && start) ||
                  ((state == STOP) && ready && !last_byte);

    tx_byte_uart #(.DIV(DIV)) u_byte (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .data  (frame_byte(sel, HDR, b1, b2)),
        .tx    (tx),
        .tick  (tick),
        .ready (ready)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_idx  <= '0;
            byte_idx <= '0;
            b1       <= '0;
            b2       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    b1       <= {3'b000, temp};
                    b2       <= {4'b0000, pres, carro, alarm};
                    byte_idx <= '0;
                    bit_idx  <= '0;
                    busy     <= 1'b1;
                    state    <= START;
                end
                START: if (tick) begin
                    bit_idx <= '0;
                    state   <= DATA;
                end
                DATA: if (tick) begin
                    if (bit_idx == BIT_W'(7)) state   <= STOP;
                    else                      bit_idx <= bit_idx + BIT_W'(1);
                end
                STOP: if (ready) begin
                    if (last_byte) begin
                        byte_idx <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        byte_idx <= byte_idx + BYTE_W'(1);
                        state    <= START;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_estado_uart.sv
// Bench for tx_estado_uart with DIV=4: expected bytes are queued at stimulus
// time and compared against bytes decoded from per-cycle samples of tx.
module tb_tx_estado_uart;
    localparam int DIV   = 4;
    localparam int FRAME = 40 * DIV;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] temp;
    logic       pres;
    logic       carro;
    logic [1:0] alarm;
    logic       tx;
    logic       busy;
    logic       done;

    int vectors;
    int miscompares;

    logic [7:0] sb[$];
    logic       txs [0:511];
    logic       bsy [0:511];
    logic       dn  [0:511];

    tx_estado_uart #(.DIV(DIV), .HDR(8'hA5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .temp  (temp),
        .pres  (pres),
        .carro (carro),
        .alarm (alarm),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_frame(input logic [4:0] t, input logic p, input logic c, input logic [1:0] a);
        logic [7:0] x1;
        logic [7:0] x2;
        x1 = {3'b000, t};
        x2 = {4'b0000, p, c, a};
        sb.push_back(8'hA5);
        sb.push_back(x1);
        sb.push_back(x2);
        sb.push_back(x1 ^ x2);
    endtask

    // Sample outputs at n consecutive negedges, starting at the current one.
    task automatic grab(input int n);
        for (int i = 0; i < n; i++) begin
            txs[i] = tx;
            bsy[i] = busy;
            dn[i]  = done;
            @(negedge clk);
        end
    endtask

    // Decode four bytes from samples starting at base; shape counts bit slots
    // that are not flat for DIV cycles, plus wrong start/stop levels.
    task automatic decode_frame(input int base, output logic [31:0] got, output int shape);
        int s;
        shape = 0;
        got   = '0;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 10; k++) begin
                s = base + 40 * j + DIV * k;
                for (int d = 1; d < DIV; d++)
                    if (txs[s + d] !== txs[s]) shape++;
                if (k == 0 && txs[s] !== 1'b0) shape++;
                if (k == 9 && txs[s] !== 1'b1) shape++;
                if (k >= 1 && k <= 8) got[8 * j + k - 1] = txs[s];
            end
        end
    endtask

    task automatic pop_compare(input string tag, input logic [31:0] got);
        logic [7:0] e;
        for (int j = 0; j < 4; j++) begin
            e = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            vectors++;
            if (got[8 * j +: 8] !== e) begin
                miscompares++;
                $display("FAIL %s byte%0d got %h expected %h", tag, j, got[8 * j +: 8], e);
            end
        end
    endtask

    task automatic test_reset;
        int bad;
        rst = 1'b0; start = 1'b0; temp = '0; pres = 0; carro = 0; alarm = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({tx, busy, done} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_values got tx/busy/done=%b expected 100", {tx, busy, done});
        end
        rst = 1'b1;
        grab(200);
        bad = 0;
        for (int i = 0; i < 200; i++)
            if (txs[i] !== 1'b1 || bsy[i] !== 1'b0 || dn[i] !== 1'b0) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL idle_quiet got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_single_frame;
        logic [31:0] got;
        int shape, nbusy, ndone;
        temp = 5'd27; pres = 1; carro = 0; alarm = 2'b10;
        start = 1'b1;
        push_frame(temp, pres, carro, alarm);
        @(negedge clk);
        start = 1'b0;
        grab(170);
        vectors++;
        if (txs[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL start_latency got tx=%b expected 0", txs[0]);
        end
        decode_frame(0, got, shape);
        pop_compare("single", got);
        vectors++;
        if (shape != 0) begin
            miscompares++;
            $display("FAIL bit_timing got %0d bad slots expected 0", shape);
        end
        nbusy = 0; ndone = 0;
        for (int i = 0; i < 170; i++) begin
            if (bsy[i] === 1'b1) nbusy++;
            if (dn[i] === 1'b1) ndone++;
        end
        vectors++;
        if (nbusy != FRAME || bsy[FRAME - 1] !== 1'b1 || bsy[FRAME] !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_width got %0d cycles expected %0d", nbusy, FRAME);
        end
        vectors++;
        if (ndone != 1 || dn[FRAME] !== 1'b1) begin
            miscompares++;
            $display("FAIL done_pulse got count %0d at160=%b expected 1 and 1", ndone, dn[FRAME]);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] got;
        int shape, guard;
        temp = 5'd31; pres = 0; carro = 0; alarm = 2'b00;
        start = 1'b1;
        push_frame(temp, pres, carro, alarm);
        push_frame(temp, pres, carro, alarm);
        @(negedge clk);
        grab(400);
        start = 1'b0;
        decode_frame(0, got, shape);
        pop_compare("b2b_first", got);
        vectors++;
        if (shape != 0) begin
            miscompares++;
            $display("FAIL b2b_first_timing got %0d bad slots expected 0", shape);
        end
        vectors++;
        if (txs[FRAME] !== 1'b1 || dn[FRAME] !== 1'b1 || txs[FRAME + 1] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap got tx=%b%b done=%b expected tx=10 done=1",
                     txs[FRAME], txs[FRAME + 1], dn[FRAME]);
        end
        decode_frame(FRAME + 1, got, shape);
        pop_compare("b2b_second", got);
        vectors++;
        if (shape != 0 || txs[2 * FRAME + 1] !== 1'b1 || txs[2 * FRAME + 2] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second_timing got %0d bad slots gap=%b%b expected 0 and 10",
                     shape, txs[2 * FRAME + 1], txs[2 * FRAME + 2]);
        end
        guard = 0;
        while (busy !== 1'b0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain got busy=%b expected 0", busy);
        end
        @(negedge clk);
    endtask

    task automatic test_capture_hold;
        logic [31:0] got;
        int shape, bad;
        temp = 5'd5; pres = 0; carro = 1; alarm = 2'b01;
        start = 1'b1;
        push_frame(temp, pres, carro, alarm);
        @(negedge clk);
        start = 1'b0;
        fork
            grab(175);
            begin
                repeat (50) @(negedge clk);
                temp = 5'd3; pres = 1; alarm = 2'b10; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (9) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        decode_frame(0, got, shape);
        pop_compare("snapshot", got);
        vectors++;
        if (shape != 0) begin
            miscompares++;
            $display("FAIL snapshot_timing got %0d bad slots expected 0", shape);
        end
        bad = 0;
        for (int i = FRAME; i < 175; i++)
            if (txs[i] !== 1'b1 || bsy[i] !== 1'b0) bad++;
        vectors++;
        if (bad != 0 || dn[FRAME] !== 1'b1) begin
            miscompares++;
            $display("FAIL ignored_start got %0d busy/tx cycles after done, done=%b expected 0 and 1",
                     bad, dn[FRAME]);
        end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] got;
        int shape;
        temp = 5'd17; pres = 1; carro = 1; alarm = 2'b11;
        start = 1'b1;
        push_frame(temp, pres, carro, alarm);
        @(negedge clk);
        start = 1'b0;
        repeat (70) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midframe_busy got %b expected 1", busy);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({tx, busy, done} !== 3'b100) begin
            miscompares++;
            $display("FAIL async_abort got tx/busy/done=%b expected 100", {tx, busy, done});
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        temp = 5'd9; pres = 1; carro = 1; alarm = 2'b11;
        start = 1'b1;
        push_frame(temp, pres, carro, alarm);
        @(negedge clk);
        start = 1'b0;
        grab(FRAME + 2);
        decode_frame(0, got, shape);
        pop_compare("after_reset", got);
        vectors++;
        if (shape != 0 || dn[FRAME] !== 1'b1) begin
            miscompares++;
            $display("FAIL after_reset_timing got %0d bad slots done=%b expected 0 and 1",
                     shape, dn[FRAME]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_capture_hold();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
